// File: rtl/state_frame_pkg.sv
// state_frame_pkg
//   Constants and FSM encoding shared by the state stream producer
//   (state_giver) and its consumer (state_uart_sender).
//   FRAME_LEN    : bytes per frame, header and footer included
//   FRAME_HEADER : first four bytes of every frame, in wire order
//   FRAME_FOOTER : last four bytes of every frame, in wire order
//   frame_state_e: sender FSM states
package state_frame_pkg;

  localparam int          FRAME_LEN    = 80;
  localparam logic [31:0] FRAME_HEADER = 32'h0A55FACE;
  localparam logic [31:0] FRAME_FOOTER = 32'hA25EFACE;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_SEND    = 2'd3
  } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   8N1 UART transmitter for one byte at a time, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   data       : byte to send, taken when valid is accepted
//   valid      : byte offered; accepted when idle or when ready is high
//   ready      : high on the last cycle of the stop bit, so the parent can
//                offer the next byte on that same cycle with no idle gap
//   txd        : serial line, idle high, registered
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;     // 0 start, 1..8 data, 9 stop
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end, load;

  assign bit_end = active_q && (baud_q == BAUD_LAST);
  assign ready   = bit_end && (bit_q == 4'd9);
  assign load    = valid && (!active_q || ready);
  assign txd     = txd_q;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    if (load) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = 4'd0;
      shift_d  = data;
      txd_d    = 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          txd_d    = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          // leaving bit 8 enters the stop bit; otherwise the next data bit
          // sits at shift_q[0]
          if (bit_q == 4'd8) begin
            txd_d = 1'b1;
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: rtl/state_uart_sender.sv
// state_uart_sender
//   Hunts the free-running state stream for a frame header, captures one
//   full frame, checks its footer and replays it over an 8N1 UART line.
//   clk, rst_n  : clock (same as the stream), asynchronous active-low reset
//   state_byte  : stream byte, new every cycle, no handshake
//   txd         : UART line, idle high
//   busy        : high from capture start until the last stop bit completes
//   frame_sent  : one-cycle pulse after the last stop bit of a frame
//   frame_err   : one-cycle pulse when a captured frame has a bad footer
//   frame_count : frames sent, wraps at 16 bits
module state_uart_sender #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_LEN    = state_frame_pkg::FRAME_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  state_byte,
  output logic        txd,
  output logic        busy,
  output logic        frame_sent,
  output logic        frame_err,
  output logic [15:0] frame_count
);

  import state_frame_pkg::*;

  localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);

  frame_state_e state_q, state_d;
  logic [31:0]  win_q, win_d;
  logic [6:0]   idx_q, idx_d;      // capture write index
  logic [6:0]   ptr_q, ptr_d;      // byte currently on the wire
  logic [15:0]  count_q, count_d;
  logic         frame_sent_q, frame_sent_d;
  logic         frame_err_q, frame_err_d;

  logic [7:0]   frame_buf_q [FRAME_LEN];
  logic         hdr_wr, cap_wr;
  logic [6:0]   rd_addr;
  logic         tx_valid, tx_ready;
  logic [7:0]   tx_data;
  logic         footer_ok;

  // The window shifts in every state, so a header that straddles the
  // return to HUNT is still seen whole on HUNT's first cycle.
  assign win_d = {win_q[23:0], state_byte};

  // During CHECK the window holds exactly the last four captured bytes
  // (buf[FRAME_LEN-4..FRAME_LEN-1]), which keeps the buffer to a single
  // read port used only by the transmitter.
  assign footer_ok = (win_q == FRAME_FOOTER);

  assign tx_data = frame_buf_q[rd_addr];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    frame_sent_d = 1'b0;
    frame_err_d  = 1'b0;
    hdr_wr       = 1'b0;
    cap_wr       = 1'b0;
    tx_valid     = 1'b0;
    rd_addr      = 7'd0;
    unique case (state_q)
      ST_HUNT: begin
        if (win_d == FRAME_HEADER) begin
          hdr_wr  = 1'b1;
          idx_d   = 7'd4;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cap_wr = 1'b1;
        idx_d  = idx_q + 7'd1;
        if (idx_q == LAST_IDX) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (footer_ok) begin
          // first byte is offered here so txd drops on the first SEND cycle
          tx_valid = 1'b1;
          rd_addr  = 7'd0;
          ptr_d    = 7'd0;
          state_d  = ST_SEND;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_HUNT;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (ptr_q == LAST_IDX) begin
            frame_sent_d = 1'b1;
            count_d      = count_q + 16'd1;
            state_d      = ST_HUNT;
          end else begin
            tx_valid = 1'b1;
            rd_addr  = ptr_q + 7'd1;
            ptr_d    = ptr_q + 7'd1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      win_q        <= 32'd0;
      idx_q        <= 7'd0;
      ptr_q        <= 7'd0;
      count_q      <= 16'd0;
      frame_sent_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      frame_sent_q <= frame_sent_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame store; contents only matter after a capture, so no reset.
  always_ff @(posedge clk) begin
    if (hdr_wr) begin
      for (int k = 0; k < 4; k++) frame_buf_q[k] <= FRAME_HEADER[8*(3-k) +: 8];
    end else if (cap_wr) begin
      frame_buf_q[idx_q] <= state_byte;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .txd  (txd)
  );

  assign busy        = (state_q != ST_HUNT);
  assign frame_sent  = frame_sent_q;
  assign frame_err   = frame_err_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_state_uart_sender.sv
module tb_state_uart_sender;

  localparam int CPB = 4;
  localparam int FL  = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  state_byte;
  logic        txd, busy, frame_sent, frame_err;
  logic [15:0] frame_count;

  int n_chk = 0;
  int n_bad = 0;

  // stream model state: byte on the bus is gen(bus_seq, bus_idx)
  int bus_idx = 0;
  int bus_seq = 0;
  bit corrupt = 0;
  bit stream_jump = 0;
  int jump_idx = 0;

  logic [7:0] rx_buf [FL];
  int rx_framing;
  bit rx_to;
  int next_exp;
  logic sent_busy;

  state_uart_sender #(.CLKS_PER_BIT(CPB), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state_byte (state_byte),
    .txd        (txd),
    .busy       (busy),
    .frame_sent (frame_sent),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // state_giver model: header, seq byte, ramp payload, footer
  function automatic logic [7:0] gen(int sq, int i, bit bad);
    logic [31:0] h;
    logic [31:0] f;
    h = 32'h0A55FACE;
    f = 32'hA25EFACE;
    if (i < 4) return h[8*(3-i) +: 8];
    if (i >= 76) begin
      if (bad && i == 77) return 8'h00;
      return f[8*(79-i) +: 8];
    end
    if (i == 4) return sq[7:0];
    return 8'((i*7 + sq) & 255);
  endfunction

  initial begin
    state_byte = gen(0, 0, 0);
    forever begin
      @(posedge clk);
      #1;
      if (stream_jump) begin
        bus_idx = jump_idx;
        stream_jump = 0;
      end else if (bus_idx == FL-1) begin
        bus_idx = 0;
        bus_seq++;
      end else begin
        bus_idx++;
      end
      state_byte = gen(bus_seq, bus_idx, corrupt);
    end
  end

  function automatic int frame_diffs(int sq);
    int d = 0;
    for (int i = 0; i < FL; i++) if (rx_buf[i] !== gen(sq, i, 0)) d++;
    return d;
  endfunction

  // seq of the first header the DUT can take if it samples the bus next edge
  function automatic int exp_from_bus();
    return (bus_idx <= 3) ? bus_seq : bus_seq + 1;
  endfunction

  function automatic int exp_after_reset();
    return (bus_idx == 0) ? bus_seq : bus_seq + 1;
  endfunction

  task automatic wait_txd_low(input int bound, output bit to);
    to = 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        to = 0;
        break;
      end
    end
  endtask

  // receives bytes first..FL-1; first start bit waited up to first_bound
  task automatic rx_frame(input int first, input int first_bound);
    rx_framing = 0;
    rx_to = 0;
    for (int b = first; b < FL; b++) begin
      bit to;
      logic [7:0] v;
      wait_txd_low((b == first) ? first_bound : CPB*12, to);
      if (to) begin
        rx_to = 1;
        return;
      end
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        v[k] = txd;
      end
      repeat (CPB) @(negedge clk);
      if (txd !== 1'b1) rx_framing++;
      rx_buf[b] = v;
    end
  endtask

  task automatic wait_sent(output int pulses, output bit to);
    to = 1;
    pulses = 0;
    sent_busy = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_sent === 1'b1) begin
        to = 0;
        sent_busy = busy;
        next_exp = exp_from_bus();
        break;
      end
    end
    if (!to) begin
      pulses = 1;
      repeat (20) begin
        @(negedge clk);
        if (frame_sent === 1'b1) pulses++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd cyc=%0d got=%b exp=1", c, txd); end
      n_chk++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, busy); end
      n_chk++;
      if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", c, frame_count); end
      n_chk++;
      if (frame_sent !== 1'b0 || frame_err !== 1'b0) begin
        n_bad++; $display("FAIL reset_pulses cyc=%0d sent=%b err=%b exp=0,0", c, frame_sent, frame_err);
      end
    end
    next_exp = exp_after_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    bit to;
    int bad_bits = 0;
    int pulses;
    logic [9:0] exp_bits;
    logic [7:0] v;
    int exp_seq = next_exp;
    exp_bits = 10'b1000010100;
    wait_txd_low(400, to);
    n_chk++;
    if (to) begin n_bad++; $display("FAIL nominal_start got=timeout exp=start bit"); return; end
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (txd !== exp_bits[k/4]) bad_bits++;
      if (k % 4 == 0 && k >= 4 && k <= 32) v[k/4 - 1] = txd;
    end
    n_chk++;
    if (bad_bits != 0) begin n_bad++; $display("FAIL first_byte_bits got=%0d bad samples exp=0", bad_bits); end
    n_chk++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL nominal_busy got=%b exp=1", busy); end
    rx_buf[0] = v;
    rx_frame(1, CPB*12);
    n_chk++;
    if (rx_to || rx_framing != 0) begin
      n_bad++; $display("FAIL nominal_rx got=to%0d framing%0d exp=0,0", rx_to, rx_framing);
    end
    n_chk++;
    if (frame_diffs(exp_seq) != 0) begin
      n_bad++; $display("FAIL nominal_bytes got=%0d wrong bytes exp=0 (seq %0d)", frame_diffs(exp_seq), exp_seq);
    end
    wait_sent(pulses, to);
    n_chk++;
    if (to || pulses != 1) begin n_bad++; $display("FAIL nominal_sent got=%0d pulses to=%0d exp=1", pulses, to); end
    n_chk++;
    if (sent_busy !== 1'b0) begin n_bad++; $display("FAIL nominal_busy_fall got=%b exp=0", sent_busy); end
    n_chk++;
    if (frame_count !== 16'd1) begin n_bad++; $display("FAIL nominal_count got=%0d exp=1", frame_count); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int pulses;
    int exp_seq = next_exp;
    rx_frame(0, 400);
    n_chk++;
    if (rx_to || rx_framing != 0) begin
      n_bad++; $display("FAIL b2b_rx got=to%0d framing%0d exp=0,0", rx_to, rx_framing);
    end
    n_chk++;
    if (frame_diffs(exp_seq) != 0) begin
      n_bad++; $display("FAIL b2b_bytes got=%0d wrong (seq byte %0d) exp=0 (seq %0d)",
                        frame_diffs(exp_seq), rx_buf[4], exp_seq & 255);
    end
    wait_sent(pulses, to);
    n_chk++;
    if (to || pulses != 1) begin n_bad++; $display("FAIL b2b_sent got=%0d pulses to=%0d exp=1", pulses, to); end
    n_chk++;
    if (frame_count !== 16'd2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", frame_count); end
  endtask

  task automatic test_footer_err();
    bit found = 0;
    int txd_bad = 0;
    corrupt = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && bus_idx == 3) begin
        found = 1;
        break;
      end
    end
    n_chk++;
    if (!found) begin n_bad++; $display("FAIL ferr_hunt got=no header exp=header"); corrupt = 0; return; end
    for (int k = 0; k < 77; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) txd_bad++;
      if (k == 0) begin
        n_chk++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_busy_rise got=%b exp=1", busy); end
      end
    end
    n_chk++;
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_early got=%b exp=0", frame_err); end
    @(negedge clk);
    n_chk++;
    if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
    n_chk++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    @(negedge clk);
    if (txd !== 1'b1) txd_bad++;
    n_chk++;
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_width got=%b exp=0", frame_err); end
    n_chk++;
    if (txd_bad != 0) begin n_bad++; $display("FAIL ferr_txd got=%0d low samples exp=0", txd_bad); end
    n_chk++;
    if (frame_count !== 16'd2) begin n_bad++; $display("FAIL ferr_count got=%0d exp=2", frame_count); end
    corrupt = 0;
  endtask

  task automatic test_mid_frame();
    bit to;
    int pulses;
    int busy_hits = 0;
    int exp_seq;
    bit seen = 0;
    @(negedge clk);
    rst_n = 1'b0;
    jump_idx = 40;
    stream_jump = 1;
    @(negedge clk);
    n_chk++;
    if (frame_count !== 16'd0) begin n_bad++; $display("FAIL mid_reset_count got=%0d exp=0", frame_count); end
    exp_seq = exp_after_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b0) busy_hits++;
      if (bus_idx == 3 && bus_seq == exp_seq) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!seen || busy_hits != 0) begin
      n_bad++; $display("FAIL mid_no_capture got=%0d busy cycles seen=%0d exp=0,1", busy_hits, seen);
    end
    rx_frame(0, 400);
    n_chk++;
    if (rx_to || rx_framing != 0 || frame_diffs(exp_seq) != 0) begin
      n_bad++; $display("FAIL mid_frame got=to%0d framing%0d diffs%0d exp=0,0,0", rx_to, rx_framing, frame_diffs(exp_seq));
    end
    wait_sent(pulses, to);
    n_chk++;
    if (to || pulses != 1 || frame_count !== 16'd1) begin
      n_bad++; $display("FAIL mid_sent got=pulses%0d count%0d exp=1,1", pulses, frame_count);
    end
  endtask

  task automatic test_reset_mid_send();
    bit to;
    int pulses;
    int exp_seq;
    int hi_bad = 0;
    wait_txd_low(400, to);
    n_chk++;
    if (to) begin n_bad++; $display("FAIL rms_start got=timeout exp=start bit"); return; end
    repeat (10*10*CPB + 5*CPB + 1) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rms_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rms_async got=txd%b busy%b exp=1,0", txd, busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (txd !== 1'b1) hi_bad++;
    end
    n_chk++;
    if (hi_bad != 0 || frame_count !== 16'd0) begin
      n_bad++; $display("FAIL rms_hold got=%0d low count%0d exp=0,0", hi_bad, frame_count);
    end
    exp_seq = exp_after_reset();
    rst_n = 1'b1;
    rx_frame(0, 400);
    n_chk++;
    if (rx_to || rx_framing != 0 || frame_diffs(exp_seq) != 0) begin
      n_bad++; $display("FAIL rms_frame got=to%0d framing%0d diffs%0d exp=0,0,0", rx_to, rx_framing, frame_diffs(exp_seq));
    end
    wait_sent(pulses, to);
    n_chk++;
    if (to || pulses != 1 || frame_count !== 16'd1) begin
      n_bad++; $display("FAIL rms_sent got=pulses%0d count%0d exp=1,1", pulses, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_footer_err();
    test_mid_frame();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
